// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared state enum, parameter defaults and field-width helper
package clock_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_e;

  localparam int DEF_TICKS_PER_SEC = 8;
  localparam int DEF_NUM_FIELDS    = 7;
  localparam int DEF_TIMEOUT_S     = 30;
  localparam int DEF_REPEAT_DLY    = 4;
  localparam int DEF_REPEAT_PER    = 1;

  // Field index width, never below one bit so a single-field build still has a port.
  function automatic int field_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - key/timebase inputs and counter-control outputs of clock_set_ctrl
interface clock_set_ctrl_if
  import clock_ctrl_pkg::*;
#(
  parameter int NUM_FIELDS = DEF_NUM_FIELDS
) ();

  localparam int FIELD_W = field_w(NUM_FIELDS);

  logic                  tick_i;
  logic                  mode_i;
  logic                  next_i;
  logic                  up_i;
  logic                  down_i;
  logic                  sec_en_o;
  logic [NUM_FIELDS-1:0] cnt_up_o;
  logic [NUM_FIELDS-1:0] cnt_down_o;
  logic [FIELD_W-1:0]    field_o;
  logic                  editing_o;
  logic                  blink_o;

  modport master (
    output tick_i, mode_i, next_i, up_i, down_i,
    input  sec_en_o, cnt_up_o, cnt_down_o, field_o, editing_o, blink_o
  );

  modport slave (
    input  tick_i, mode_i, next_i, up_i, down_i,
    output sec_en_o, cnt_up_o, cnt_down_o, field_o, editing_o, blink_o
  );

endinterface

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - press edge detection plus hold-to-repeat for one up/down key
module key_repeat #(
  parameter int REPEAT_DLY = 4,
  parameter int REPEAT_PER = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic tick_i,
  input  logic key_i,
  output logic press_o,
  output logic rpt_o
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             key_q, key_d;
  logic             held_q, held_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= 1'b1;
      held_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      key_q   <= key_d;
      held_q  <= held_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  // Until armed, cnt measures the initial hold delay; afterwards the repeat period.
  always_comb begin
    key_d   = key_i;
    held_d  = held_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    rpt_o   = 1'b0;
    if (!key_i || !en_i) begin
      held_d  = 1'b0;
      armed_d = 1'b0;
      cnt_d   = '0;
    end
    if (key_i && !key_q && en_i) begin
      press_o = 1'b1;
      held_d  = 1'b1;
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (key_i && en_i && held_q && tick_i) begin
      if (armed_q ? (cnt_inc == CNT_W'(REPEAT_PER)) : (cnt_inc == CNT_W'(REPEAT_DLY))) begin
        rpt_o   = 1'b1;
        armed_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - RUN/EDIT controller for a clock: seconds enable, field select,
// up/down step pulses with auto-repeat, blink and edit timeout.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int NUM_FIELDS    = DEF_NUM_FIELDS,
  parameter int TIMEOUT_S     = DEF_TIMEOUT_S,
  parameter int REPEAT_DLY    = DEF_REPEAT_DLY,
  parameter int REPEAT_PER    = DEF_REPEAT_PER
) (
  input  logic            clk,
  input  logic            rst,
  clock_set_ctrl_if.slave bus
);

  localparam int FIELD_W  = field_w(NUM_FIELDS);
  localparam int TICK_W   = $clog2(TICKS_PER_SEC);
  localparam int HALF_SEC = TICKS_PER_SEC / 2;
  localparam int IDLE_MAX = TIMEOUT_S * TICKS_PER_SEC;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  state_e                state_q, state_d;
  logic [FIELD_W-1:0]    field_q, field_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  blink_q, blink_d;
  logic                  sec_en_q, sec_en_d;
  logic [NUM_FIELDS-1:0] cnt_up_q, cnt_up_d;
  logic [NUM_FIELDS-1:0] cnt_down_q, cnt_down_d;
  logic                  mode_q, mode_d;
  logic                  next_q, next_d;

  logic mode_press, next_press;
  logic up_lvl, down_lvl, step_en;
  logic up_press, up_rpt, down_press, down_rpt;

  assign mode_press = bus.mode_i & ~mode_q;
  assign next_press = bus.next_i & ~next_q;

  // Both step keys down together reads as neither; a higher-priority press cancels any hold.
  assign up_lvl   = bus.up_i & ~bus.down_i;
  assign down_lvl = bus.down_i & ~bus.up_i;
  assign step_en  = (state_q == ST_EDIT) & ~mode_press & ~next_press;

  key_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_up_key (
    .clk     (clk),
    .rst     (rst),
    .en_i    (step_en),
    .tick_i  (bus.tick_i),
    .key_i   (up_lvl),
    .press_o (up_press),
    .rpt_o   (up_rpt)
  );

  key_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_down_key (
    .clk     (clk),
    .rst     (rst),
    .en_i    (step_en),
    .tick_i  (bus.tick_i),
    .key_i   (down_lvl),
    .press_o (down_press),
    .rpt_o   (down_rpt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      field_q    <= '0;
      tick_q     <= '0;
      idle_q     <= '0;
      blink_q    <= 1'b0;
      sec_en_q   <= 1'b0;
      cnt_up_q   <= '0;
      cnt_down_q <= '0;
      mode_q     <= 1'b1;
      next_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      tick_q     <= tick_d;
      idle_q     <= idle_d;
      blink_q    <= blink_d;
      sec_en_q   <= sec_en_d;
      cnt_up_q   <= cnt_up_d;
      cnt_down_q <= cnt_down_d;
      mode_q     <= mode_d;
      next_q     <= next_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    tick_d     = tick_q;
    idle_d     = idle_q;
    blink_d    = blink_q;
    sec_en_d   = 1'b0;
    cnt_up_d   = '0;
    cnt_down_d = '0;
    mode_d     = bus.mode_i;
    next_d     = bus.next_i;
    case (state_q)
      ST_RUN: begin
        blink_d = 1'b0;
        if (mode_press) begin
          state_d = ST_EDIT;
          field_d = '0;
          blink_d = 1'b1;
          tick_d  = '0;
          idle_d  = '0;
        end else if (bus.tick_i) begin
          if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
            tick_d   = '0;
            sec_en_d = 1'b1;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      ST_EDIT: begin
        if (mode_press) begin
          state_d = ST_RUN;
          tick_d  = '0;
          idle_d  = '0;
          blink_d = 1'b0;
        end else begin
          // In EDIT the tick counter paces the blink at half-second steps.
          if (bus.tick_i) begin
            if (tick_q == TICK_W'(HALF_SEC - 1)) begin
              tick_d  = '0;
              blink_d = ~blink_q;
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end
          if (next_press) begin
            field_d = (field_q == FIELD_W'(NUM_FIELDS - 1)) ? '0 : field_q + FIELD_W'(1);
            idle_d  = '0;
          end else if (up_press || up_rpt) begin
            cnt_up_d[field_q] = 1'b1;
            idle_d            = '0;
          end else if (down_press || down_rpt) begin
            cnt_down_d[field_q] = 1'b1;
            idle_d              = '0;
          end else if (bus.tick_i) begin
            if (idle_q == IDLE_W'(IDLE_MAX - 1)) begin
              state_d = ST_RUN;
              tick_d  = '0;
              idle_d  = '0;
              blink_d = 1'b0;
            end else begin
              idle_d = idle_q + IDLE_W'(1);
            end
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.sec_en_o   = sec_en_q;
  assign bus.cnt_up_o   = cnt_up_q;
  assign bus.cnt_down_o = cnt_down_q;
  assign bus.field_o    = field_q;
  assign bus.editing_o  = (state_q == ST_EDIT);
  assign bus.blink_o    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  clock_set_ctrl_if #(.NUM_FIELDS(7)) bus ();

  clock_set_ctrl #(
    .TICKS_PER_SEC (8),
    .NUM_FIELDS    (7),
    .TIMEOUT_S     (30),
    .REPEAT_DLY    (4),
    .REPEAT_PER    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic enter_edit();
    bus.mode_i = 1'b1;
    step();
    bus.mode_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.editing_o, bus.sec_en_o, bus.blink_o, bus.field_o, bus.cnt_up_o, bus.cnt_down_o} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ed=%b sec=%b bl=%b fld=%0d up=%b dn=%b required all zero",
               bus.editing_o, bus.sec_en_o, bus.blink_o, bus.field_o, bus.cnt_up_o, bus.cnt_down_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_run_seconds();
    int pulses;
    pulses = 0;
    for (int t = 1; t <= 16; t++) begin
      bus.tick_i = 1'b1;
      step();
      bus.tick_i = 1'b0;
      pulses += int'(bus.sec_en_o);
      checks++;
      if (bus.sec_en_o !== ((t % 8) == 0)) begin
        errors++;
        $display("FAIL run_sec_en tick %0d: got %b required %b", t, bus.sec_en_o, (t % 8) == 0);
      end
      for (int c = 0; c < 3; c++) begin
        step();
        checks++;
        if ({bus.sec_en_o, bus.cnt_up_o, bus.cnt_down_o} !== 15'h0) begin
          errors++;
          $display("FAIL run_quiet tick %0d: got sec=%b up=%b dn=%b required 0",
                   t, bus.sec_en_o, bus.cnt_up_o, bus.cnt_down_o);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL run_sec_count: got %0d required 2", pulses);
    end
  endtask

  task automatic test_field_select();
    bus.mode_i = 1'b1;
    step();
    bus.mode_i = 1'b0;
    checks++;
    if ({bus.editing_o, bus.blink_o, bus.field_o} !== {1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL edit_entry: got ed=%b bl=%b fld=%0d required ed=1 bl=1 fld=0",
               bus.editing_o, bus.blink_o, bus.field_o);
    end
    step();
    for (int n = 0; n < 3; n++) begin
      bus.next_i = 1'b1;
      step();
      bus.next_i = 1'b0;
      step();
    end
    checks++;
    if (bus.field_o !== 3'd3) begin
      errors++;
      $display("FAIL field_after_next3: got %0d required 3", bus.field_o);
    end
    bus.up_i = 1'b1;
    step();
    checks++;
    if (bus.cnt_up_o !== 7'b0001000 || bus.cnt_down_o !== 7'b0) begin
      errors++;
      $display("FAIL up_pulse_field3: got up=%b dn=%b required up=0001000 dn=0", bus.cnt_up_o, bus.cnt_down_o);
    end
    step();
    checks++;
    if (bus.cnt_up_o !== 7'b0) begin
      errors++;
      $display("FAIL up_pulse_width: got %b required 0", bus.cnt_up_o);
    end
    bus.up_i = 1'b0;
    step();
    for (int n = 0; n < 4; n++) begin
      bus.next_i = 1'b1;
      step();
      bus.next_i = 1'b0;
      step();
      checks++;
      if (bus.field_o !== 3'((4 + n) % 7)) begin
        errors++;
        $display("FAIL field_wrap step %0d: got %0d required %0d", n, bus.field_o, (4 + n) % 7);
      end
    end
    enter_edit();
    checks++;
    if (bus.editing_o !== 1'b0) begin
      errors++;
      $display("FAIL mode_exit: got %b required 0", bus.editing_o);
    end
  endtask

  task automatic test_repeat();
    int pulses;
    logic [6:0] exp;
    enter_edit();
    bus.down_i = 1'b1;
    step();
    pulses = int'(bus.cnt_down_o[0]);
    checks++;
    if (bus.cnt_down_o !== 7'b1) begin
      errors++;
      $display("FAIL down_press: got %b required 0000001", bus.cnt_down_o);
    end
    for (int t = 1; t <= 8; t++) begin
      bus.tick_i = 1'b1;
      step();
      bus.tick_i = 1'b0;
      exp = (t >= 4) ? 7'b1 : 7'b0;
      pulses += int'(bus.cnt_down_o[0]);
      checks++;
      if (bus.cnt_down_o !== exp || bus.cnt_up_o !== 7'b0) begin
        errors++;
        $display("FAIL down_repeat tick %0d: got dn=%b up=%b required dn=%b up=0", t, bus.cnt_down_o, bus.cnt_up_o, exp);
      end
      step();
    end
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL down_repeat_count: got %0d required 6", pulses);
    end
    bus.down_i = 1'b0;
    step();
    bus.up_i   = 1'b1;
    bus.down_i = 1'b1;
    for (int t = 0; t < 6; t++) begin
      bus.tick_i = 1'b1;
      step();
      bus.tick_i = 1'b0;
      checks++;
      if (bus.cnt_up_o !== 7'b0 || bus.cnt_down_o !== 7'b0) begin
        errors++;
        $display("FAIL both_keys cycle %0d: got up=%b dn=%b required 0", t, bus.cnt_up_o, bus.cnt_down_o);
      end
    end
    bus.up_i   = 1'b0;
    bus.down_i = 1'b0;
    step();
  endtask

  task automatic test_priority();
    bus.mode_i = 1'b1;
    bus.up_i   = 1'b1;
    step();
    checks++;
    if (bus.editing_o !== 1'b0 || bus.cnt_up_o !== 7'b0 || bus.cnt_down_o !== 7'b0) begin
      errors++;
      $display("FAIL mode_over_up: got ed=%b up=%b dn=%b required ed=0 up=0 dn=0", bus.editing_o, bus.cnt_up_o, bus.cnt_down_o);
    end
    bus.mode_i = 1'b0;
    bus.up_i   = 1'b0;
    step();
    for (int t = 1; t <= 8; t++) begin
      bus.tick_i = 1'b1;
      step();
      bus.tick_i = 1'b0;
      checks++;
      if (bus.sec_en_o !== (t == 8)) begin
        errors++;
        $display("FAIL sec_after_exit tick %0d: got %b required %b", t, bus.sec_en_o, t == 8);
      end
    end
  endtask

  task automatic test_timeout();
    enter_edit();
    for (int t = 1; t <= 240; t++) begin
      bus.tick_i = 1'b1;
      step();
      bus.tick_i = 1'b0;
      checks++;
      if (bus.editing_o !== (t < 240)) begin
        errors++;
        $display("FAIL timeout_editing tick %0d: got %b required %b", t, bus.editing_o, t < 240);
      end
      checks++;
      if (bus.blink_o !== ((t < 240) && (((t / 4) % 2) == 0))) begin
        errors++;
        $display("FAIL timeout_blink tick %0d: got %b required %b", t, bus.blink_o, (t < 240) && (((t / 4) % 2) == 0));
      end
    end
  endtask

  task automatic test_reset_mid_edit();
    enter_edit();
    bus.next_i = 1'b1;
    step();
    bus.next_i = 1'b0;
    step();
    rst      = 1'b1;
    bus.up_i = 1'b1;
    step();
    checks++;
    if ({bus.editing_o, bus.field_o, bus.cnt_up_o, bus.blink_o} !== 12'h0) begin
      errors++;
      $display("FAIL reset_mid_edit: got ed=%b fld=%0d up=%b bl=%b required 0", bus.editing_o, bus.field_o, bus.cnt_up_o, bus.blink_o);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.cnt_up_o !== 7'b0 || bus.editing_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_up_held: got up=%b ed=%b required 0", bus.cnt_up_o, bus.editing_o);
    end
    bus.up_i = 1'b0;
    step();
  endtask

  task automatic test_mode_held_reset();
    bus.mode_i = 1'b1;
    rst        = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (bus.editing_o !== 1'b0) begin
      errors++;
      $display("FAIL mode_held_reset: got %b required 0", bus.editing_o);
    end
    bus.mode_i = 1'b0;
    step();
    bus.mode_i = 1'b1;
    step();
    checks++;
    if (bus.editing_o !== 1'b1) begin
      errors++;
      $display("FAIL mode_after_release: got %b required 1", bus.editing_o);
    end
    bus.mode_i = 1'b0;
    step();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.tick_i  = 1'b0;
    bus.mode_i  = 1'b0;
    bus.next_i  = 1'b0;
    bus.up_i    = 1'b0;
    bus.down_i  = 1'b0;
    test_reset();
    test_run_seconds();
    test_field_select();
    test_repeat();
    test_priority();
    test_timeout();
    test_reset_mid_edit();
    test_mode_held_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
